// File: rtl/mips_pkg.sv
// Shared fetch-path types and constants: address/instruction widths, reset PC, queue entry.
// No logic here; imported by the fetch unit and its instruction queue.
package mips_pkg;

    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 64;
    localparam logic [ADDR_W-1:0] RESET_PC = '0;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Instruction queue: DEPTH x fetch_entry_t, head visible combinationally, flush clears it.
// Latency 1 cycle push-to-head; caller must not push when full; output holds last popped entry when empty.
module sync_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  fetch_entry_t           push_dat,
    input  logic                   pop,
    output fetch_entry_t           head_dat,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t      mem_q [DEPTH];
    fetch_entry_t      mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    fetch_entry_t      hold_q, hold_d;
    logic              full;
    logic              push_ok;
    logic              pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign push_ok = push && !flush;
    assign pop_ok  = pop && !empty && !flush;
    assign count   = count_q;
    // Once drained, decode keeps seeing the last instruction it consumed.
    assign head_dat = empty ? hold_q : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        hold_d   = hold_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                hold_d   = mem_q[rd_ptr_q];
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            hold_q   <= hold_d;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push_ok && full && !pop_ok));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns PC, issues 1-cycle RAM reads, queues {instr,pc} for decode.
// First instr 2 cycles after issue; reads are credit-limited so the queue never overflows under instr_ready=0.
module fetch_unit
    import mips_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_adr,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_adr,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr_data,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready
);

    logic [ADDR_W-1:0]      pc_q, pc_d;
    logic                   inflight_q, inflight_d;
    logic [ADDR_W-1:0]      inflight_pc_q, inflight_pc_d;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   fifo_empty;
    logic                   fifo_push;
    logic                   fifo_pop;
    fetch_entry_t           push_dat;
    fetch_entry_t           head_dat;

    // A read may only go out if a queue slot is guaranteed for its response.
    assign mem_req = !rst && !redirect
                     && ((int'(fifo_count) + int'(inflight_q)) < DEPTH);
    assign mem_adr = pc_q;

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = mem_req;
        inflight_pc_d = pc_q;
        if (redirect) begin
            pc_d = redirect_adr;
        end else if (mem_req) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    // A response arriving during a redirect belongs to the old stream and is dropped.
    assign fifo_push   = inflight_q && !redirect;
    assign push_dat    = '{instr: mem_rdata, pc: inflight_pc_q};
    assign instr_valid = !fifo_empty && !redirect;
    assign fifo_pop    = instr_valid && instr_ready;
    assign instr_data  = head_dat.instr;
    assign instr_pc    = head_dat.pc;

    sync_fifo #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect),
        .push     (fifo_push),
        .push_dat (push_dat),
        .pop      (fifo_pop),
        .head_dat (head_dat),
        .count    (fifo_count),
        .empty    (fifo_empty)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: vector table for reset/stream start, directed corner sequences,
// then random ready/redirect/reset traffic against an in-order stream scoreboard.
module tb_fetch_unit;
    import mips_pkg::*;

    localparam int DEPTH = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               mem_req;
    logic [ADDR_W-1:0]  mem_adr;
    logic [INSTR_W-1:0] mem_rdata = '0;
    logic               redirect = 1'b0;
    logic [ADDR_W-1:0]  redirect_adr = '0;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr_data;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_ready = 1'b0;

    always #5 clk = ~clk;

    fetch_unit #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_req      (mem_req),
        .mem_adr      (mem_adr),
        .mem_rdata    (mem_rdata),
        .redirect     (redirect),
        .redirect_adr (redirect_adr),
        .instr_valid  (instr_valid),
        .instr_data   (instr_data),
        .instr_pc     (instr_pc),
        .instr_ready  (instr_ready)
    );

    // RAM[a] = 3*a for small addresses; high address bits also reach the upper data bits.
    function automatic logic [63:0] ram_val(input logic [15:0] a);
        return (64'(a) * 64'd3) + (64'(a >> 8) << 40);
    endfunction

    always @(posedge clk) begin
        if (mem_req) mem_rdata <= ram_val(mem_adr);
        else         mem_rdata <= 64'hDEAD_BEEF_DEAD_BEEF;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference stream model
    logic              armed = 1'b0;
    logic [15:0]       exp_pc = '0;
    logic [15:0]       exp_iss = '0;
    int                since = 1000;
    int                outstanding = 0;
    int                n_req = 0;
    int                n_acc = 0;
    logic              prev_hold = 1'b0;
    logic [15:0]       prev_pc = '0;
    logic [63:0]       prev_dat = '0;
    logic [15:0]       acc_q[$];

    task automatic flush_model(input logic [15:0] target);
        exp_pc      = target;
        exp_iss     = target;
        since       = 0;
        outstanding = 0;
        prev_hold   = 1'b0;
    endtask

    task automatic tick(input logic r, input logic rd, input logic [15:0] ra, input logic rdy);
        @(negedge clk);
        rst = r; redirect = rd; redirect_adr = ra; instr_ready = rdy;
        #4;
        if (armed) begin
            if (since < 1000) since++;
            if (r) begin
                check("req_in_rst", 64'(mem_req), 64'(1'b0));
            end else begin
                if (rd) begin
                    check("vld_in_redirect", 64'(instr_valid), 64'(1'b0));
                    check("req_in_redirect", 64'(mem_req), 64'(1'b0));
                end else if (since < 3) begin
                    check("vld_latency_lo", 64'(instr_valid), 64'(1'b0));
                end else if (since == 3) begin
                    check("vld_latency_hi", 64'(instr_valid), 64'(1'b1));
                end
                if (prev_hold && !rd) begin
                    check("hold_vld", 64'(instr_valid), 64'(1'b1));
                    check("hold_pc", 64'(instr_pc), 64'(prev_pc));
                    check("hold_dat", instr_data, prev_dat);
                end
                if (mem_req) begin
                    check("issue_adr", 64'(mem_adr), 64'(exp_iss));
                    exp_iss++;
                    outstanding++;
                    n_req++;
                    check("credit", 64'(outstanding <= DEPTH), 64'(1'b1));
                end
                if (instr_valid && rdy && !rd) begin
                    check("acc_pc", 64'(instr_pc), 64'(exp_pc));
                    check("acc_dat", instr_data, ram_val(exp_pc));
                    acc_q.push_back(instr_pc);
                    exp_pc++;
                    outstanding--;
                    n_acc++;
                end
            end
        end
        if (r) begin
            armed = 1'b1;
            flush_model(RESET_PC);
        end else if (rd) begin
            flush_model(ra);
        end else begin
            prev_hold = instr_valid && !rdy;
            prev_pc   = instr_pc;
            prev_dat  = instr_data;
        end
    endtask

    task automatic check_acc(input string name, input int idx, input logic [15:0] exp);
        if (acc_q.size() > idx) check(name, 64'(acc_q[idx]), 64'(exp));
        else                    check(name, 64'(acc_q.size()), 64'(idx + 1));
    endtask

    typedef struct {
        logic        r;
        logic        rdy;
        logic        chk;
        logic        req;
        logic [15:0] adr;
        logic        vld;
        logic [15:0] pc;
        logic [63:0] dat;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic rdy, input logic chk, input logic req,
                                input int adr, input logic vld, input int pc, input int dat);
        vec_t v;
        v.r = r; v.rdy = rdy; v.chk = chk; v.req = req;
        v.adr = 16'(adr); v.vld = vld; v.pc = 16'(pc); v.dat = 64'(dat);
        return v;
    endfunction

    vec_t vecs [9];

    initial begin
        int base;

        vecs[0] = mk(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 0);
        vecs[1] = mk(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 0);
        vecs[2] = mk(1'b0, 1'b1, 1'b1, 1'b1, 0, 1'b0, 0, 0);
        vecs[3] = mk(1'b0, 1'b1, 1'b1, 1'b1, 1, 1'b0, 0, 0);
        vecs[4] = mk(1'b0, 1'b1, 1'b1, 1'b1, 2, 1'b1, 0, 0);
        vecs[5] = mk(1'b0, 1'b1, 1'b1, 1'b1, 3, 1'b1, 1, 3);
        vecs[6] = mk(1'b0, 1'b1, 1'b1, 1'b1, 4, 1'b1, 2, 6);
        vecs[7] = mk(1'b0, 1'b1, 1'b1, 1'b1, 5, 1'b1, 3, 9);
        vecs[8] = mk(1'b0, 1'b1, 1'b1, 1'b1, 6, 1'b1, 4, 12);

        // Reset state and gap-free streaming from RESET_PC
        for (int i = 0; i < 9; i++) begin
            tick(vecs[i].r, 1'b0, 16'h0, vecs[i].rdy);
            if (vecs[i].chk) begin
                check($sformatf("tbl%0d_req", i), 64'(mem_req), 64'(vecs[i].req));
                if (vecs[i].req) check($sformatf("tbl%0d_adr", i), 64'(mem_adr), 64'(vecs[i].adr));
                check($sformatf("tbl%0d_vld", i), 64'(instr_valid), 64'(vecs[i].vld));
                check($sformatf("tbl%0d_pc", i), 64'(instr_pc), 64'(vecs[i].pc));
                check($sformatf("tbl%0d_dat", i), instr_data, vecs[i].dat);
            end
        end

        // Backpressure: exactly DEPTH reads, head held, then lossless resume
        tick(1'b1, 1'b0, 16'h0, 1'b0);
        tick(1'b1, 1'b0, 16'h0, 1'b0);
        base = n_req;
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 16'h0, 1'b0);
        check("t2_reqs", 64'(n_req - base), 64'(DEPTH));
        check("t2_req_off", 64'(mem_req), 64'(1'b0));
        check("t2_head_vld", 64'(instr_valid), 64'(1'b1));
        check("t2_head_pc", 64'(instr_pc), 64'(16'h0));
        acc_q.delete();
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 16'h0, 1'b1);
        for (int k = 0; k < 8; k++) check_acc($sformatf("t2_acc%0d", k), k, 16'(k));

        // Redirect with 3 queued and 1 in flight
        tick(1'b1, 1'b0, 16'h0, 1'b0);
        tick(1'b1, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 16'h0, 1'b0);
        check("t3_pre_vld", 64'(instr_valid), 64'(1'b1));
        tick(1'b0, 1'b1, 16'h0100, 1'b1);
        check("t3_redir_vld", 64'(instr_valid), 64'(1'b0));
        tick(1'b0, 1'b0, 16'h0, 1'b1);
        check("t3_next_vld", 64'(instr_valid), 64'(1'b0));
        acc_q.delete();
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 16'h0, 1'b1);
        check_acc("t3_first", 0, 16'h0100);
        check_acc("t3_second", 1, 16'h0101);

        // PC wrap through 0xFFFF
        tick(1'b0, 1'b1, 16'hFFFE, 1'b1);
        acc_q.delete();
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 16'h0, 1'b1);
        check_acc("t4_acc0", 0, 16'hFFFE);
        check_acc("t4_acc1", 1, 16'hFFFF);
        check_acc("t4_acc2", 2, 16'h0000);
        check_acc("t4_acc3", 3, 16'h0001);

        // Reset mid-stream with a full queue
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 16'h0, 1'b1);
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 16'h0, 1'b0);
        check("t5_pre_vld", 64'(instr_valid), 64'(1'b1));
        tick(1'b1, 1'b0, 16'h0, 1'b0);
        tick(1'b1, 1'b0, 16'h0, 1'b0);
        check("t5_rst_vld", 64'(instr_valid), 64'(1'b0));
        check("t5_rst_req", 64'(mem_req), 64'(1'b0));
        check("t5_rst_pc", 64'(instr_pc), 64'(16'h0));
        check("t5_rst_dat", instr_data, 64'h0);
        acc_q.delete();
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 16'h0, 1'b1);
        check_acc("t5_acc0", 0, RESET_PC);
        check_acc("t5_acc1", 1, RESET_PC + 16'h1);

        // Random traffic
        base = n_acc;
        for (int i = 0; i < 4000; i++) begin
            logic r, rd, rdy;
            logic [15:0] ra;
            r   = ($urandom_range(0, 255) == 0);
            rd  = ($urandom_range(0, 23) == 0);
            ra  = 16'($urandom);
            rdy = ($urandom_range(0, 3) != 0);
            tick(r, rd, ra, rdy);
        end
        check("t6_progress", 64'(n_acc - base > 1000), 64'(1'b1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
